// File: rtl/periph_bus_pkg.sv
// -----------------------------------------------------------------------------
// periph_bus_pkg
// Shared definitions for the calculator peripheral port.
//   - command op encodings used on cmd_op
//   - FSM state encoding of the command master
//   - default register map constants (status / result / busy bit) that the
//     peripheral wrappers reuse so both sides agree on the layout
// -----------------------------------------------------------------------------
package periph_bus_pkg;

    // Command opcodes; OP_RSVD is accepted and behaves like OP_READ.
    typedef enum logic [1:0] {
        OP_WRITE   = 2'd0,
        OP_READ    = 2'd1,
        OP_COMPUTE = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    // Command master FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_SETTLE = 3'd2,
        ST_PRD    = 3'd3,
        ST_PWAIT  = 3'd4,
        ST_RD     = 3'd5,
        ST_RWAIT  = 3'd6,
        ST_RESP   = 3'd7
    } state_e;

    // Default register map of compute-style peripherals.
    localparam logic [4:0] DEF_STATUS_ADDR = 5'h04;
    localparam logic [4:0] DEF_RESULT_ADDR = 5'h08;
    localparam int         DEF_BUSY_BIT    = 0;

    // True for ops whose first bus access is a write.
    function automatic logic op_writes_first(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_COMPUTE);
    endfunction

endpackage

// File: rtl/periph_cmd_master.sv
// -----------------------------------------------------------------------------
// periph_cmd_master
// Bus initiator for the calculator peripheral port. Takes one command at a
// time on a valid/ready port, performs single-cycle peripheral accesses and
// returns read data / compute results on a valid/ready response port.
// COMPUTE runs write operand -> settle -> poll status until not busy (bounded
// by MAX_POLLS) -> read result.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_op, cmd_addr, cmd_wdata payload
//   resp_valid/ready    response handshake; resp_data, resp_timeout payload
//   cs, addr, rd, wr    peripheral bus controls (addr is 0 whenever cs=0)
//   d_out               write data to peripheral (0 whenever cs=0)
//   d_in                peripheral read data, valid the cycle after rd
//
// All outputs are registers loaded from the decode of the next state, so the
// visible bus/handshake signals line up with the state the FSM is in.
// -----------------------------------------------------------------------------
module periph_cmd_master
    import periph_bus_pkg::*;
#(
    parameter int               ADDR_W      = 5,
    parameter int               WDATA_W     = 16,
    parameter int               RDATA_W     = 32,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter logic [ADDR_W-1:0] RESULT_ADDR = DEF_RESULT_ADDR,
    parameter int               BUSY_BIT    = DEF_BUSY_BIT,
    parameter int               MAX_POLLS   = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [WDATA_W-1:0] cmd_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [RDATA_W-1:0] resp_data,
    output logic               resp_timeout,
    output logic               cs,
    output logic [ADDR_W-1:0]  addr,
    output logic               rd,
    output logic               wr,
    output logic [WDATA_W-1:0] d_out,
    input  logic [RDATA_W-1:0] d_in
);

    localparam int                POLL_W   = $clog2(MAX_POLLS + 1);
    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(MAX_POLLS);

    state_e               state_r;
    state_e               state_nxt_s;
    logic [1:0]           op_r;
    logic [1:0]           op_nxt_s;
    logic [ADDR_W-1:0]    addr_r;
    logic [ADDR_W-1:0]    addr_nxt_s;
    logic [WDATA_W-1:0]   wdata_r;
    logic [WDATA_W-1:0]   wdata_nxt_s;
    logic [POLL_W-1:0]    poll_r;

    logic                 accept_s;
    logic                 busy_s;
    logic                 poll_done_s;

    logic                 cs_nxt_s;
    logic                 rd_nxt_s;
    logic                 wr_nxt_s;
    logic [ADDR_W-1:0]    addr_out_nxt_s;
    logic [WDATA_W-1:0]   d_out_nxt_s;

    // cmd_ready is a register, so it is low for the first cycle after reset
    // release and no command can slip in during that cycle.
    assign accept_s    = cmd_valid & cmd_ready;
    assign busy_s      = d_in[BUSY_BIT];
    assign poll_done_s = (poll_r == POLL_MAX);

    // Command fields as they will be held after this edge (new on accept).
    always_comb begin
        if (accept_s) begin
            op_nxt_s    = cmd_op;
            addr_nxt_s  = cmd_addr;
            wdata_nxt_s = cmd_wdata;
        end else begin
            op_nxt_s    = op_r;
            addr_nxt_s  = addr_r;
            wdata_nxt_s = wdata_r;
        end
    end

    // Next-state logic of the access sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = op_writes_first(cmd_op) ? ST_WR : ST_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR: begin
                if (op_r == OP_COMPUTE) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_SETTLE: state_nxt_s = ST_PRD;
            ST_PRD:    state_nxt_s = ST_PWAIT;
            ST_PWAIT: begin
                if (!busy_s) begin
                    state_nxt_s = ST_RD;
                end else if (poll_done_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_PRD;
                end
            end
            ST_RD:    state_nxt_s = ST_RWAIT;
            ST_RWAIT: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Bus controls decoded from the next state; only access states drive cs.
    always_comb begin
        cs_nxt_s       = 1'b0;
        rd_nxt_s       = 1'b0;
        wr_nxt_s       = 1'b0;
        addr_out_nxt_s = {ADDR_W{1'b0}};
        d_out_nxt_s    = {WDATA_W{1'b0}};
        case (state_nxt_s)
            ST_WR: begin
                cs_nxt_s       = 1'b1;
                wr_nxt_s       = 1'b1;
                addr_out_nxt_s = addr_nxt_s;
                d_out_nxt_s    = wdata_nxt_s;
            end
            ST_PRD: begin
                cs_nxt_s       = 1'b1;
                rd_nxt_s       = 1'b1;
                addr_out_nxt_s = STATUS_ADDR;
            end
            ST_RD: begin
                cs_nxt_s       = 1'b1;
                rd_nxt_s       = 1'b1;
                addr_out_nxt_s = (op_nxt_s == OP_COMPUTE) ? RESULT_ADDR : addr_nxt_s;
            end
            default: begin
                cs_nxt_s       = 1'b0;
                rd_nxt_s       = 1'b0;
                wr_nxt_s       = 1'b0;
                addr_out_nxt_s = {ADDR_W{1'b0}};
                d_out_nxt_s    = {WDATA_W{1'b0}};
            end
        endcase
    end

    // FSM state, latched command, poll counter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            op_r         <= 2'd0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {WDATA_W{1'b0}};
            poll_r       <= {POLL_W{1'b0}};
            cmd_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= {RDATA_W{1'b0}};
            resp_timeout <= 1'b0;
            cs           <= 1'b0;
            rd           <= 1'b0;
            wr           <= 1'b0;
            addr         <= {ADDR_W{1'b0}};
            d_out        <= {WDATA_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            op_r       <= op_nxt_s;
            addr_r     <= addr_nxt_s;
            wdata_r    <= wdata_nxt_s;
            cmd_ready  <= (state_nxt_s == ST_IDLE);
            resp_valid <= (state_nxt_s == ST_RESP);
            cs         <= cs_nxt_s;
            rd         <= rd_nxt_s;
            wr         <= wr_nxt_s;
            addr       <= addr_out_nxt_s;
            d_out      <= d_out_nxt_s;

            // Counts issued status reads; saturates so it can never wrap.
            if (accept_s) begin
                poll_r <= {POLL_W{1'b0}};
            end else if ((state_r == ST_PRD) && !poll_done_s) begin
                poll_r <= poll_r + {{(POLL_W-1){1'b0}}, 1'b1};
            end else begin
                poll_r <= poll_r;
            end

            // Response payload is zero unless a data read completes.
            if (accept_s) begin
                resp_data <= {RDATA_W{1'b0}};
            end else if (state_r == ST_RWAIT) begin
                resp_data <= d_in;
            end else begin
                resp_data <= resp_data;
            end

            if (accept_s) begin
                resp_timeout <= 1'b0;
            end else if ((state_r == ST_PWAIT) && busy_s && poll_done_s) begin
                resp_timeout <= 1'b1;
            end else begin
                resp_timeout <= resp_timeout;
            end
        end
    end

endmodule

// File: tb/tb_periph_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_periph_cmd_master
// Directed bench for periph_cmd_master (MAX_POLLS=4) with a small peripheral
// model: status reads report busy for a configurable number of reads (or
// forever), every other read returns rd_value. A negedge monitor counts bus
// accesses so the step sequence can compare access counts per command.
// -----------------------------------------------------------------------------
module tb_periph_cmd_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic [31:0] d_in = 32'd0;

    // peripheral model configuration (written by the stimulus only)
    int          busy_reads  = 0;
    logic        stuck       = 1'b0;
    logic [31:0] rd_value    = 32'd0;
    int          status_base = 0;

    // monitor counters (written by the monitor only)
    int          n_wr     = 0;
    int          n_status = 0;
    int          n_result = 0;
    int          n_other  = 0;
    int          n_strobe = 0;
    int          n_viol   = 0;
    logic [4:0]  last_wr_addr = 5'd0;
    logic [15:0] last_wr_data = 16'd0;
    logic [4:0]  last_rd_addr = 5'd0;

    int checks   = 0;
    int failures = 0;

    // snapshots
    int s_wr, s_status, s_result, s_other, s_strobe;

    periph_cmd_master #(.MAX_POLLS(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_timeout(resp_timeout),
        .cs(cs), .addr(addr), .rd(rd), .wr(wr), .d_out(d_out), .d_in(d_in)
    );

    always #5 clk = ~clk;

    // Peripheral model and bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if ((rd || wr) && !cs) n_viol <= n_viol + 1;
        if (!cs && (addr != 5'd0 || d_out != 16'd0)) n_viol <= n_viol + 1;
        if (rd && wr) n_viol <= n_viol + 1;
        if (rd || wr) n_strobe <= n_strobe + 1;
        if (cs && wr) begin
            n_wr         <= n_wr + 1;
            last_wr_addr <= addr;
            last_wr_data <= d_out;
        end
        if (cs && rd) begin
            last_rd_addr <= addr;
            if (addr == 5'h04) begin
                n_status <= n_status + 1;
                d_in     <= {31'd0, (stuck || ((n_status - status_base) < busy_reads))};
            end else begin
                if (addr == 5'h08) n_result <= n_result + 1;
                else               n_other  <= n_other + 1;
                d_in <= rd_value;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_wr = n_wr; s_status = n_status; s_result = n_result;
        s_other = n_other; s_strobe = n_strobe;
    endtask

    // Presents a command in a cycle where cmd_ready is expected high and
    // returns just after the accept edge (cycle 1).
    task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [15:0] wd);
        chk("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Waits for resp_valid (bounded) and checks the cycle it appeared in.
    task automatic wait_resp(input string tag, input int exp_lat);
        int cyc;
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(tag, cyc, exp_lat);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_valid_after_hs", {31'd0, resp_valid}, 32'd0);
        chk("cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 5'd0;
        cmd_wdata = 16'd0; resp_ready = 1'b0;

        // ---- reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", {31'd0, cs}, 32'd0);
        chk("rst_rdwr", {30'd0, rd, wr}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // ---- WRITE addr 0, 0x0305
        snap();
        issue(2'd0, 5'd0, 16'h0305);
        chk("wr_strobe", {29'd0, cs, wr, rd}, 32'b110);
        chk("wr_d_out", {16'd0, d_out}, 32'h0305);
        chk("wr_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        wait_resp("wr_latency", 2);
        chk("wr_resp_data", resp_data, 32'd0);
        chk("wr_timeout", {31'd0, resp_timeout}, 32'd0);
        chk("wr_count", n_wr - s_wr, 32'd1);
        chk("wr_addr", {27'd0, last_wr_addr}, 32'd0);
        chk("wr_data", {16'd0, last_wr_data}, 32'h0305);
        chk("wr_no_reads", (n_status + n_result + n_other) - (s_status + s_result + s_other), 32'd0);
        handshake();

        // ---- READ addr 8
        rd_value = 32'h0000_000F;
        snap();
        issue(2'd1, 5'h08, 16'h0000);
        wait_resp("rd_latency", 3);
        chk("rd_data", resp_data, 32'h0000_000F);
        chk("rd_count", n_result - s_result, 32'd1);
        chk("rd_addr", {27'd0, last_rd_addr}, 32'h08);
        chk("rd_strobes", n_strobe - s_strobe, 32'd1);
        handshake();

        // ---- COMPUTE: busy for 3 status reads, result 0xF
        busy_reads = 3; rd_value = 32'h0000_000F; status_base = n_status;
        snap();
        issue(2'd2, 5'd0, 16'h0305);
        wait_resp("cmp_latency", 13);
        chk("cmp_data", resp_data, 32'h0000_000F);
        chk("cmp_timeout", {31'd0, resp_timeout}, 32'd0);
        chk("cmp_wr", n_wr - s_wr, 32'd1);
        chk("cmp_status_reads", n_status - s_status, 32'd4);
        chk("cmp_result_reads", n_result - s_result, 32'd1);
        handshake();

        // ---- COMPUTE timeout: busy stuck, MAX_POLLS=4
        stuck = 1'b1; status_base = n_status;
        snap();
        issue(2'd2, 5'd1, 16'h0007);
        wait_resp("to_latency", 11);
        chk("to_flag", {31'd0, resp_timeout}, 32'd1);
        chk("to_data", resp_data, 32'd0);
        chk("to_status_reads", n_status - s_status, 32'd4);
        chk("to_result_reads", n_result - s_result, 32'd0);
        handshake();
        stuck = 1'b0;

        // ---- reserved op acts as READ; stall in RESP with a new command waiting
        rd_value = 32'hA5A5_1234;
        snap();
        issue(2'd3, 5'h10, 16'h0000);
        wait_resp("rsv_latency", 3);
        chk("rsv_other_read", n_other - s_other, 32'd1);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 5'd3; cmd_wdata = 16'h1111;
        snap();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall_data", resp_data, 32'hA5A5_1234);
            chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        chk("stall_no_strobes", n_strobe - s_strobe, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("held_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("held_cmd_accepted", {31'd0, cmd_ready}, 32'd0);
        chk("held_wr", {29'd0, cs, wr, rd}, 32'b110);
        chk("held_addr_data", {11'd0, addr, d_out}, {11'd0, 5'd3, 16'h1111});
        wait_resp("held_latency", 2);
        handshake();

        // ---- reset during PWAIT of a COMPUTE
        stuck = 1'b1; status_base = n_status;
        issue(2'd2, 5'd0, 16'h0002);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_prd", {29'd0, cs, wr, rd}, 32'b101);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_bus", {29'd0, cs, wr, rd}, 32'd0);
        chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        stuck = 1'b0;
        snap();
        repeat (3) @(posedge clk);
        #1;
        chk("after_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("after_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("after_rst_no_strobes", n_strobe - s_strobe, 32'd0);
        rd_value = 32'h0000_BEEF;
        issue(2'd1, 5'h02, 16'h0000);
        wait_resp("after_rst_rd_latency", 3);
        chk("after_rst_rd_data", resp_data, 32'h0000_BEEF);
        chk("after_rst_rd_timeout", {31'd0, resp_timeout}, 32'd0);
        handshake();

        chk("bus_protocol_violations", n_viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
